// File: rtl/id_ex_stage_pkg.sv
// Shared widths, encodings and stage-register layouts for the b-risc ID/EX stages.
package id_ex_stage_pkg;

    localparam int ADDR_W     = 32;
    localparam int INSTR_W    = 32;
    localparam int WORD_W     = 32;
    localparam int REG_IDX_W  = 5;
    localparam int ALU_OP_W   = 4;
    localparam int MEM_OP_W   = 5;
    localparam int DEST_SRC_W = 2;
    localparam int NUM_REGS   = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [DEST_SRC_W-1:0] {
        DEST_NONE = 2'd0,
        DEST_ALU  = 2'd1,
        DEST_MEM  = 2'd2
    } dest_src_t;

    // Upper two bits of the memory-op field; the low three carry funct3.
    localparam logic [1:0] MEM_KIND_NONE  = 2'b00;
    localparam logic [1:0] MEM_KIND_LOAD  = 2'b01;
    localparam logic [1:0] MEM_KIND_STORE = 2'b10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [INSTR_W-1:0]   instr;
        alu_op_t              alu_op;
        logic [WORD_W-1:0]    a;
        logic [WORD_W-1:0]    b;
        logic [MEM_OP_W-1:0]  mem_op;
        logic [WORD_W-1:0]    store_data;
        dest_src_t            dest_src;
        logic [REG_IDX_W-1:0] dest_reg;
    } id_reg_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [INSTR_W-1:0]   instr;
        logic [MEM_OP_W-1:0]  mem_op;
        logic [WORD_W-1:0]    store_data;
        dest_src_t            dest_src;
        logic [REG_IDX_W-1:0] dest_reg;
        logic [WORD_W-1:0]    alu_eval;
    } ex_reg_t;

    // alt is funct7[5]; callers mask it off where it must not select SUB.
    function automatic alu_op_t alu_op_of(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ex_stage_alu.sv
// Combinational RV32I integer ALU; shift amounts come from b[4:0].
module id_ex_stage_alu
    import id_ex_stage_pkg::*;
(
    input  alu_op_t           op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(WORD_W-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage_reg_file.sv
// 32-entry, two-read one-write register file with x0 hardwired to zero and
// write-through bypass so a same-cycle writeback is visible to decode.
module id_ex_stage_reg_file
    import id_ex_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic [WORD_W-1:0]    rs1_data,
    output logic [WORD_W-1:0]    rs2_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [WORD_W-1:0]    wr_data
);

    logic [WORD_W-1:0] regs [NUM_REGS];

    // Whole-array asynchronous clear rules out block RAM; this is a flop array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    function automatic logic [WORD_W-1:0] read_port(input logic [REG_IDX_W-1:0] idx);
        logic [WORD_W-1:0] val;
        if (idx == '0)
            val = '0;
        else if (wr_en && (wr_idx == idx))
            val = wr_data;
        else
            val = regs[idx];
        return val;
    endfunction

    assign rs1_data = read_port(rs1_idx);
    assign rs2_data = read_port(rs2_idx);

endmodule

// File: rtl/id_ex_stage.sv
// Decode + execute stages: decoder and register-file read feed the ID register,
// the ALU feeds the EX register that drives the memory stage.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rf_reset,
    input  logic                  id_clr,
    input  logic                  id_stall,
    input  logic                  ex_clr,
    input  logic                  ex_stall,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic                  i_wb_dest_en,
    input  logic [REG_IDX_W-1:0]  i_wb_dest_reg,
    input  logic [WORD_W-1:0]     i_wb_dest_data,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [MEM_OP_W-1:0]   o_mem_op,
    output logic [WORD_W-1:0]     o_store_data,
    output logic [DEST_SRC_W-1:0] o_dest_src,
    output logic [REG_IDX_W-1:0]  o_dest_reg,
    output logic [WORD_W-1:0]     o_alu_eval
);

    id_reg_t id_reg, id_next;
    ex_reg_t ex_reg, ex_next;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [REG_IDX_W-1:0] rd, rs1, rs2;
    logic [WORD_W-1:0]    rs1_data, rs2_data;
    logic [WORD_W-1:0]    imm_i, imm_s, imm_u;
    logic [WORD_W-1:0]    alu_y;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_u  = {i_instr[31:12], 12'b0};

    id_ex_stage_reg_file u_reg_file (
        .clk      (clk),
        .rst      (rf_reset),
        .rs1_idx  (rs1),
        .rs2_idx  (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (i_wb_dest_en),
        .wr_idx   (i_wb_dest_reg),
        .wr_data  (i_wb_dest_data)
    );

    // Unknown opcodes fall through the defaults: a bubble that still carries pc/instr.
    always_comb begin
        id_next          = '0;
        id_next.pc       = i_pc;
        id_next.instr    = i_instr;
        id_next.alu_op   = ALU_ADD;
        id_next.dest_src = DEST_NONE;
        case (opcode)
            OPC_OP: begin
                id_next.a        = rs1_data;
                id_next.b        = rs2_data;
                id_next.alu_op   = alu_op_of(funct3, i_instr[30]);
                id_next.dest_src = DEST_ALU;
                id_next.dest_reg = rd;
            end
            OPC_OP_IMM: begin
                id_next.a        = rs1_data;
                id_next.b        = imm_i;
                // ADDI has no subtract form; only SRAI uses funct7[5].
                id_next.alu_op   = alu_op_of(funct3, (funct3 == F3_SRL_SRA) && i_instr[30]);
                id_next.dest_src = DEST_ALU;
                id_next.dest_reg = rd;
            end
            OPC_LUI: begin
                id_next.b        = imm_u;
                id_next.dest_src = DEST_ALU;
                id_next.dest_reg = rd;
            end
            OPC_AUIPC: begin
                id_next.a        = i_pc;
                id_next.b        = imm_u;
                id_next.dest_src = DEST_ALU;
                id_next.dest_reg = rd;
            end
            OPC_LOAD: begin
                id_next.a        = rs1_data;
                id_next.b        = imm_i;
                id_next.mem_op   = {MEM_KIND_LOAD, funct3};
                id_next.dest_src = DEST_MEM;
                id_next.dest_reg = rd;
            end
            OPC_STORE: begin
                id_next.a          = rs1_data;
                id_next.b          = imm_s;
                id_next.mem_op     = {MEM_KIND_STORE, funct3};
                id_next.store_data = rs2_data;
            end
            default: ;
        endcase
        if (id_next.dest_reg == '0) begin
            id_next.dest_src = DEST_NONE;
        end
    end

    always_ff @(posedge clk or posedge rf_reset) begin
        if (rf_reset)
            id_reg <= '0;
        else if (id_clr)
            id_reg <= '0;
        else if (!id_stall)
            id_reg <= id_next;
    end

    id_ex_stage_alu u_alu (
        .op (id_reg.alu_op),
        .a  (id_reg.a),
        .b  (id_reg.b),
        .y  (alu_y)
    );

    always_comb begin
        ex_next            = '0;
        ex_next.pc         = id_reg.pc;
        ex_next.instr      = id_reg.instr;
        ex_next.mem_op     = id_reg.mem_op;
        ex_next.store_data = id_reg.store_data;
        ex_next.dest_src   = id_reg.dest_src;
        ex_next.dest_reg   = id_reg.dest_reg;
        ex_next.alu_eval   = alu_y;
    end

    always_ff @(posedge clk or posedge rf_reset) begin
        if (rf_reset)
            ex_reg <= '0;
        else if (ex_clr)
            ex_reg <= '0;
        else if (!ex_stall)
            ex_reg <= ex_next;
    end

    assign o_pc         = ex_reg.pc;
    assign o_instr      = ex_reg.instr;
    assign o_mem_op     = ex_reg.mem_op;
    assign o_store_data = ex_reg.store_data;
    assign o_dest_src   = ex_reg.dest_src;
    assign o_dest_reg   = ex_reg.dest_reg;
    assign o_alu_eval   = ex_reg.alu_eval;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic, all checked
// against an instruction-level model of the two stages and the register file.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rf_reset, id_clr, id_stall, ex_clr, ex_stall;
    logic [31:0] i_pc, i_instr;
    logic        i_wb_dest_en;
    logic [4:0]  i_wb_dest_reg;
    logic [31:0] i_wb_dest_data;
    logic [31:0] o_pc, o_instr, o_store_data, o_alu_eval;
    logic [4:0]  o_mem_op, o_dest_reg;
    logic [1:0]  o_dest_src;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  mem_op;
        logic [31:0] store;
        logic [1:0]  dest_src;
        logic [4:0]  dest_reg;
        logic [31:0] alu;
    } exp_t;

    exp_t        id_m, ex_m;
    logic [31:0] mregs [32];

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rf_reset(rf_reset), .id_clr(id_clr), .id_stall(id_stall),
        .ex_clr(ex_clr), .ex_stall(ex_stall), .i_pc(i_pc), .i_instr(i_instr),
        .i_wb_dest_en(i_wb_dest_en), .i_wb_dest_reg(i_wb_dest_reg),
        .i_wb_dest_data(i_wb_dest_data), .o_pc(o_pc), .o_instr(o_instr),
        .o_mem_op(o_mem_op), .o_store_data(o_store_data), .o_dest_src(o_dest_src),
        .o_dest_reg(o_dest_reg), .o_alu_eval(o_alu_eval)
    );

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    // Register value as decode sees it, including a same-cycle writeback.
    function automatic logic [31:0] rv(logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (i_wb_dest_en && i_wb_dest_reg == r) return i_wb_dest_data;
        return mregs[r];
    endfunction

    function automatic logic [31:0] alu_ref(logic [2:0] f3, logic alt, logic [31:0] x, logic [31:0] y);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Architectural effect of one instruction, as it should leave the EX stage.
    function automatic exp_t ref_exec(logic [31:0] pc, logic [31:0] ins);
        exp_t e;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] x, y, imm_i, imm_s, imm_u;
        rd = ins[11:7];
        f3 = ins[14:12];
        x = rv(ins[19:15]);
        y = rv(ins[24:20]);
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_u = {ins[31:12], 12'b0};
        e = '0;
        e.pc = pc;
        e.instr = ins;
        case (ins[6:0])
            7'b0110011: begin e.alu = alu_ref(f3, ins[30], x, y); e.dest_src = 2'd1; e.dest_reg = rd; end
            7'b0010011: begin e.alu = alu_ref(f3, ins[30] && f3 == 3'd5, x, imm_i); e.dest_src = 2'd1; e.dest_reg = rd; end
            7'b0110111: begin e.alu = imm_u; e.dest_src = 2'd1; e.dest_reg = rd; end
            7'b0010111: begin e.alu = pc + imm_u; e.dest_src = 2'd1; e.dest_reg = rd; end
            7'b0000011: begin e.alu = x + imm_i; e.mem_op = {2'b01, f3}; e.dest_src = 2'd2; e.dest_reg = rd; end
            7'b0100011: begin e.alu = x + imm_s; e.mem_op = {2'b10, f3}; e.store = y; end
            default: ;
        endcase
        if (rd == 5'd0) e.dest_src = 2'd0;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ".pc"}, o_pc, ex_m.pc);
        chk({tag, ".instr"}, o_instr, ex_m.instr);
        chk({tag, ".mem_op"}, 32'(o_mem_op), 32'(ex_m.mem_op));
        chk({tag, ".dest_src"}, 32'(o_dest_src), 32'(ex_m.dest_src));
        chk({tag, ".dest_reg"}, 32'(o_dest_reg), 32'(ex_m.dest_reg));
        chk({tag, ".alu_eval"}, o_alu_eval, ex_m.alu);
        if (ex_m.mem_op[4:3] == 2'b10) chk({tag, ".store_data"}, o_store_data, ex_m.store);
        $display("t=%0t %s pc=%h instr=%h alu=%h dst=%0d/%0d mem=%b", $time, tag,
                 o_pc, o_instr, o_alu_eval, o_dest_src, o_dest_reg, o_mem_op);
    endtask

    task automatic tick(string tag);
        exp_t d;
        d = ref_exec(i_pc, i_instr);
        @(posedge clk);
        if (ex_clr) ex_m = '0; else if (!ex_stall) ex_m = id_m;
        if (id_clr) id_m = '0; else if (!id_stall) id_m = d;
        if (i_wb_dest_en && i_wb_dest_reg != 5'd0) mregs[i_wb_dest_reg] = i_wb_dest_data;
        #1;
        compare_all(tag);
    endtask

    task automatic issue(logic [31:0] ins, string tag);
        i_instr = ins;
        i_pc = i_pc + 32'd4;
        tick(tag);
    endtask

    task automatic wb(logic [4:0] r, logic [31:0] v);
        i_wb_dest_en = 1'b1; i_wb_dest_reg = r; i_wb_dest_data = v;
        issue(NOP, "wb");
        i_wb_dest_en = 1'b0;
    endtask

    task automatic model_reset();
        id_m = '0;
        ex_m = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    endtask

    task automatic read_all_zero(string tag);
        for (int k = 1; k < 32; k++) issue(enc_i(12'd0, 5'(k), 3'd0, 5'd1, 7'b0010011), tag);
        issue(NOP, tag);
        issue(NOP, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rf_reset = 1'b1; id_clr = 0; id_stall = 0; ex_clr = 0; ex_stall = 0;
        i_pc = 32'h1000; i_instr = NOP;
        i_wb_dest_en = 0; i_wb_dest_reg = 0; i_wb_dest_data = 0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        compare_all("reset");
        rf_reset = 1'b0;
        read_all_zero("rd0");

        issue(32'hFFF0_0093, "addi_m1");
        issue(NOP, "addi_m1+1");
        chk("addi_m1.alu_lit", o_alu_eval, 32'hFFFF_FFFF);
        chk("addi_m1.dst_lit", 32'(o_dest_reg), 32'd1);

        wb(5'd2, 32'd5);
        wb(5'd3, 32'd7);
        issue(enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd4), "add");
        issue(enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd4), "sub");
        chk("add.lit", o_alu_eval, 32'd12);
        issue(enc_r(7'h00, 5'd3, 5'd2, 3'd2, 5'd4), "slt");
        chk("sub.lit", o_alu_eval, 32'hFFFF_FFFE);
        issue(enc_r(7'h20, 5'd3, 5'd2, 3'd5, 5'd4), "sra");
        chk("slt.lit", o_alu_eval, 32'd1);
        issue(NOP, "nop");
        chk("sra.lit", o_alu_eval, 32'd0);

        wb(5'd3, 32'h8000_0000);
        issue(enc_i(12'h404, 5'd3, 3'd5, 5'd7, 7'b0010011), "srai");
        issue(NOP, "nop");
        chk("srai.lit", o_alu_eval, 32'hF800_0000);

        i_wb_dest_en = 1; i_wb_dest_reg = 5'd5; i_wb_dest_data = 32'd5;
        issue(enc_i(12'd1, 5'd5, 3'd0, 5'd6, 7'b0010011), "bypass");
        i_wb_dest_reg = 5'd0; i_wb_dest_data = 32'h55;
        issue(enc_i(12'd0, 5'd0, 3'd0, 5'd8, 7'b0010011), "x0wr");
        chk("bypass.lit", o_alu_eval, 32'd6);
        i_wb_dest_en = 0;
        issue(NOP, "nop");
        chk("x0wr.lit", o_alu_eval, 32'd0);

        wb(5'd3, 32'h100);
        issue(enc_s(12'd8, 5'd2, 5'd3, 3'd2), "sw");
        issue(enc_i(12'd8, 5'd3, 3'd2, 5'd10, 7'b0000011), "lw");
        chk("sw.alu_lit", o_alu_eval, 32'h108);
        chk("sw.mem_lit", 32'(o_mem_op), 32'b10010);
        chk("sw.data_lit", o_store_data, 32'd5);
        chk("sw.src_lit", 32'(o_dest_src), 32'd0);
        issue(NOP, "nop");
        chk("lw.src_lit", 32'(o_dest_src), 32'd2);

        issue(enc_i(12'd77, 5'd0, 3'd0, 5'd11, 7'b0010011), "pre_stall");
        id_stall = 1;
        for (int s = 0; s < 3; s++) begin
            issue(enc_i(12'd99, 5'd0, 3'd0, 5'd12, 7'b0010011), "id_stall");
            chk("id_stall.lit", o_alu_eval, 32'd77);
        end
        id_clr = 1;
        issue(NOP, "id_clr");
        id_clr = 0; id_stall = 0;
        issue(NOP, "after_clr");
        chk("id_clr.src_lit", 32'(o_dest_src), 32'd0);
        chk("id_clr.alu_lit", o_alu_eval, 32'd0);
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd13, 7'b0010011), "pre_exclr");
        ex_clr = 1;
        issue(NOP, "ex_clr");
        ex_clr = 0;
        chk("ex_clr.src_lit", 32'(o_dest_src), 32'd0);
        chk("ex_clr.alu_lit", o_alu_eval, 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [2:0]  kind;
            logic [4:0]  rd, rs1, rs2;
            logic [2:0]  f3;
            kind = 3'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            f3 = 3'($urandom);
            case (kind)
                3'd0, 3'd1: ins = enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
                3'd2: ins = enc_i(12'($urandom), rs1, f3, rd, 7'b0010011);
                3'd3: ins = {20'($urandom), rd, 7'b0110111};
                3'd4: ins = {20'($urandom), rd, 7'b0010111};
                3'd5: ins = enc_i(12'($urandom), rs1, f3, rd, 7'b0000011);
                3'd6: ins = enc_s(12'($urandom), rs2, rs1, f3);
                default: ins = {25'($urandom), 7'b1101111};
            endcase
            i_wb_dest_en = ($urandom_range(0, 1) != 0);
            i_wb_dest_reg = 5'($urandom_range(0, 7));
            i_wb_dest_data = $urandom;
            id_stall = ($urandom_range(0, 7) == 0);
            ex_stall = ($urandom_range(0, 7) == 0);
            id_clr = ($urandom_range(0, 15) == 0);
            ex_clr = ($urandom_range(0, 15) == 0);
            i_pc = $urandom & 32'hFFFF_FFFC;
            i_instr = ins;
            tick("rand");
        end
        id_stall = 0; ex_stall = 0; id_clr = 0; ex_clr = 0; i_wb_dest_en = 0;
        i_instr = 32'h0123_4537;
        tick("pre_rst");

        #2;
        rf_reset = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        @(posedge clk);
        #1;
        rf_reset = 1'b0;
        read_all_zero("rd0_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
